// File: rtl/adder_pkg.sv
// Shared constants, stage-count helper and per-stage pipeline record for pipe_cla_adder.
package adder_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_SEG   = 16;

  function automatic int unsigned calc_nseg(input int unsigned width, input int unsigned seg);
    return width / seg;
  endfunction

  typedef struct packed {
    logic valid;
    logic carry;
    logic msb_a;
    logic msb_b;
  } stage_rec_t;

endpackage

// File: rtl/cla_segment.sv
// Combinational SEG-bit carry-lookahead adder: every carry is a flat
// generate/propagate expression of the segment inputs and cin.
module cla_segment #(
  parameter int unsigned SEG = 16
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] s,
  output logic           cout
);

  logic [SEG-1:0] g;
  logic [SEG-1:0] p;
  logic [SEG:0]   c;
  logic           gen_t;
  logic           prop_t;

  assign g = a & b;
  assign p = a ^ b;

  // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]cin
  always_comb begin
    c      = '0;
    gen_t  = 1'b0;
    prop_t = 1'b0;
    c[0]   = cin;
    for (int i = 0; i < int'(SEG); i++) begin
      gen_t  = g[i];
      prop_t = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        gen_t  = gen_t | (prop_t & g[j]);
        prop_t = prop_t & p[j];
      end
      c[i+1] = gen_t | (prop_t & cin);
    end
  end

  assign s    = p ^ c[SEG-1:0];
  assign cout = c[SEG];

endmodule

// File: rtl/pipe_cla_adder.sv
// Pipelined segmented CLA adder/subtractor with valid/ready backpressure.
// Define ADDER_FLAGS_EN to build the ovf/zero flags and MSB carry-forward.
module pipe_cla_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SEG   = DEF_SEG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NSEG = calc_nseg(WIDTH, SEG);

  if (SEG == 0 || (WIDTH % SEG) != 0 || NSEG < 1) begin : g_bad_cfg
    $error("pipe_cla_adder: WIDTH must be a non-zero multiple of SEG");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin0;

  // Whole pipeline moves together unless the output is held
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign b_eff    = sub ? ~b : b;
  assign cin0     = sub | c_in;

  for (genvar k = 0; k < int'(NSEG); k++) begin : g_stage
    localparam int unsigned REM = WIDTH - k * SEG;

    logic [REM-1:0]         a_in;
    logic [REM-1:0]         b_in;
    logic                   ci;
    logic                   v_in;
    logic [SEG-1:0]         s_seg;
    logic                   co;
    logic [(k+1)*SEG-1:0]   s_acc;
`ifdef ADDER_FLAGS_EN
    logic                   ma_in;
    logic                   mb_in;
`endif

    if (k == 0) begin : g_src
      assign a_in  = a;
      assign b_in  = b_eff;
      assign ci    = cin0;
      assign v_in  = in_valid;
      assign s_acc = s_seg;
`ifdef ADDER_FLAGS_EN
      assign ma_in = a[WIDTH-1];
      assign mb_in = b_eff[WIDTH-1];
`endif
    end else begin : g_src
      assign a_in  = g_stage[k-1].g_pipe.a_sk;
      assign b_in  = g_stage[k-1].g_pipe.b_sk;
      assign ci    = g_stage[k-1].g_pipe.rec.carry;
      assign v_in  = g_stage[k-1].g_pipe.rec.valid;
      assign s_acc = {s_seg, g_stage[k-1].g_pipe.s_dk};
`ifdef ADDER_FLAGS_EN
      assign ma_in = g_stage[k-1].g_pipe.rec.msb_a;
      assign mb_in = g_stage[k-1].g_pipe.rec.msb_b;
`endif
    end

    cla_segment #(.SEG(SEG)) u_cla (
      .a    (a_in[SEG-1:0]),
      .b    (b_in[SEG-1:0]),
      .cin  (ci),
      .s    (s_seg),
      .cout (co)
    );

    if (k < int'(NSEG) - 1) begin : g_pipe
      stage_rec_t             rec;
      logic [REM-SEG-1:0]     a_sk;
      logic [REM-SEG-1:0]     b_sk;
      logic [(k+1)*SEG-1:0]   s_dk;

      // Only the record needs reset; data of an invalid stage is don't-care
      always_ff @(posedge clk) begin
        if (rst) begin
          rec <= '0;
        end else if (adv) begin
          rec.valid <= v_in;
          rec.carry <= co;
`ifdef ADDER_FLAGS_EN
          rec.msb_a <= ma_in;
          rec.msb_b <= mb_in;
`endif
        end
      end

      always_ff @(posedge clk) begin
        if (adv) begin
          a_sk <= a_in[REM-1:SEG];
          b_sk <= b_in[REM-1:SEG];
          s_dk <= s_acc;
        end
      end
    end else begin : g_out
      always_ff @(posedge clk) begin
        if (rst) begin
          out_valid <= 1'b0;
          sum       <= '0;
          c_out     <= 1'b0;
          ovf       <= 1'b0;
          zero      <= 1'b0;
        end else if (adv) begin
          out_valid <= v_in;
          sum       <= s_acc;
          c_out     <= co;
`ifdef ADDER_FLAGS_EN
          ovf       <= (ma_in == mb_in) && (s_seg[SEG-1] != ma_in);
          zero      <= ~|s_acc;
`else
          ovf       <= 1'b0;
          zero      <= 1'b0;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_cla_adder.sv
// Self-checking bench for pipe_cla_adder: arithmetic model + scoreboard on the
// 32/16 instance, directed literal checks, and a 64/16 carry-ripple check.
module tb_pipe_cla_adder;

`ifdef ADDER_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  logic        in_valid, in_ready, c_in, sub, out_valid, out_ready, c_out, ovf, zero;
  logic [31:0] a, b, sum;

  logic        in_valid64, in_ready64, out_valid64, c_out64, ovf64, zero64;
  logic [63:0] a64, b64, sum64;

  int total = 0;
  int bad   = 0;
  int n_out = 0;

  typedef struct packed {
    logic [31:0] sum;
    logic        c;
    logic        ovf;
    logic        z;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  pipe_cla_adder #(.WIDTH(32), .SEG(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .ovf(ovf), .zero(zero)
  );

  pipe_cla_adder #(.WIDTH(64), .SEG(16)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid64), .in_ready(in_ready64),
    .a(a64), .b(b64), .c_in(1'b0), .sub(1'b0),
    .out_valid(out_valid64), .out_ready(1'b1),
    .sum(sum64), .c_out(c_out64), .ovf(ovf64), .zero(zero64)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Plain-arithmetic reference: unsigned 33-bit result and signed range test
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic ci, input logic s);
    exp_t        e;
    logic [32:0] full;
    longint      sr;
    if (s) begin
      full = {1'b0, x} + 33'h1_0000_0000 - {1'b0, y};
      sr   = longint'($signed(x)) - longint'($signed(y));
    end else begin
      full = {1'b0, x} + {1'b0, y} + {32'd0, ci};
      sr   = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
    end
    e.sum = full[31:0];
    e.c   = full[32];
    e.ovf = FLAGS && (sr > 64'sd2147483647 || sr < -64'sd2147483648);
    e.z   = FLAGS && (full[31:0] == 32'd0);
    return e;
  endfunction

  // Scoreboard: push on accept, pop and compare on emit, stability during stall
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      check("in_ready_rule", {63'd0, in_ready}, {63'd0, (!out_valid || out_ready)});
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("stale_result", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("sb_sum",   {32'd0, sum},   {32'd0, e.sum});
          check("sb_c_out", {63'd0, c_out}, {63'd0, e.c});
          check("sb_ovf",   {63'd0, ovf},   {63'd0, e.ovf});
          check("sb_zero",  {63'd0, zero},  {63'd0, e.z});
          n_out++;
        end
      end else if (out_valid && !out_ready && q.size() > 0) begin
        check("stall_hold_sum", {32'd0, sum}, {32'd0, q[0].sum});
      end
      if (in_valid && in_ready) q.push_back(model(a, b, c_in, sub));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single beat on an empty pipeline with out_ready=1; latency must be 2
  task automatic one_beat(input string name, input logic [31:0] x, input logic [31:0] y,
                          input logic ci, input logic s, input logic [31:0] rsum,
                          input logic rc, input logic rovf, input logic rz);
    in_valid = 1'b1; a = x; b = y; c_in = ci; sub = s;
    tick();
    in_valid = 1'b0;
    check({name, "_lat1_valid"}, {63'd0, out_valid}, 64'd0);
    tick();
    check({name, "_valid"}, {63'd0, out_valid}, 64'd1);
    check({name, "_sum"},   {32'd0, sum},       {32'd0, rsum});
    check({name, "_c_out"}, {63'd0, c_out},     {63'd0, rc});
    check({name, "_ovf"},   {63'd0, ovf},       {63'd0, rovf});
    check({name, "_zero"},  {63'd0, zero},      {63'd0, rz});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int n0;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
    in_valid64 = 1'b0; a64 = '0; b64 = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_sum",       {32'd0, sum},       64'd0);
    check("rst_c_out",     {63'd0, c_out},     64'd0);
    check("rst_ovf",       {63'd0, ovf},       64'd0);
    check("rst_zero",      {63'd0, zero},      64'd0);
    check("rst_in_ready",  {63'd0, in_ready},  64'd1);
    check("rst_valid64",   {63'd0, out_valid64}, 64'd0);

    one_beat("wrap",     32'hFFFF_FFFF, 32'h1,    1'b0, 1'b0, 32'h0,         1'b1, 1'b0,  FLAGS);
    one_beat("sub_brw",  32'd5,         32'd7,    1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0,  1'b0);
    one_beat("pos_ovf",  32'h7FFF_FFFF, 32'h1,    1'b0, 1'b0, 32'h8000_0000, 1'b0, FLAGS, 1'b0);
    one_beat("cin_ign",  32'd10,        32'd3,    1'b1, 1'b1, 32'd7,         1'b1, 1'b0,  1'b0);
    one_beat("seg_cin",  32'h0000_FFFF, 32'h0,    1'b1, 1'b0, 32'h0001_0000, 1'b0, 1'b0,  1'b0);
    one_beat("neg_ovf",  32'h8000_0000, 32'h1,    1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, FLAGS, 1'b0);
    one_beat("sub_eq",   32'h1234,      32'h1234, 1'b0, 1'b1, 32'h0,         1'b1, 1'b0,  FLAGS);
    tick();

    // Back-to-back beats with a 3-cycle output stall
    n0 = n_out;
    in_valid = 1'b1; a = 32'd1; b = 32'd1; c_in = 1'b0; sub = 1'b0;
    tick();
    a = 32'd2; b = 32'd2;
    tick();
    a = 32'd3; b = 32'd3; out_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("stall_in_ready",  {63'd0, in_ready},  64'd0);
      check("stall_out_valid", {63'd0, out_valid}, 64'd1);
      check("stall_sum",       {32'd0, sum},       64'd2);
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("drain_sum4", {32'd0, sum}, 64'd4);
    tick();
    check("drain_sum6", {32'd0, sum}, 64'd6);
    tick();
    tick();
    check("stall_count", 64'(n_out - n0), 64'd3);

    // Reset with two beats in flight
    in_valid = 1'b1; a = 32'd10; b = 32'd10;
    tick();
    a = 32'd20; b = 32'd20;
    tick();
    rst = 1'b1; in_valid = 1'b0;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_sum",   {32'd0, sum},       64'd0);
    check("mid_rst_c_out", {63'd0, c_out},     64'd0);
    check("mid_rst_flags", {62'd0, ovf, zero}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      check("post_rst_no_stale", {63'd0, out_valid}, 64'd0);
      tick();
    end
    one_beat("recover", 32'd100, 32'd23, 1'b0, 1'b0, 32'd123, 1'b0, 1'b0, 1'b0);
    tick();

    // 64-bit instance: carry ripples through four registered stages
    in_valid64 = 1'b1; a64 = 64'h0000_FFFF_FFFF_FFFF; b64 = 64'h1;
    tick();
    in_valid64 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("w64_latency", {63'd0, out_valid64}, 64'd0);
      tick();
    end
    check("w64_valid", {63'd0, out_valid64}, 64'd1);
    check("w64_sum",   sum64,                64'h0001_0000_0000_0000);
    check("w64_c_out", {63'd0, c_out64},     64'd0);
    check("w64_flags", {62'd0, ovf64, zero64}, 64'd0);
    check("w64_ready", {63'd0, in_ready64},  64'd1);
    tick();

    check("sb_empty", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
